// File: rtl/io_interrupt_bridge_pkg.sv
// Shared types for the I/O interrupt bridge: interrupt FSM encoding and Status bit positions.
package io_interrupt_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_WAIT  = 2'd2
    } int_state_e;

    localparam int STATUS_W       = 4;
    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_UNDERFLOW = 2;
    localparam int STAT_OVERFLOW  = 3;

endpackage

// File: rtl/io_interrupt_bridge_if.sv
// Signal bundle between the bridge (slave) and its environment: external source/sink plus processor.
interface io_interrupt_bridge_if
    import io_interrupt_bridge_pkg::*;
#(
    parameter int DATA_W = 16
);
    // Handshakes: a word moves on a rising clk edge where valid && ready are both 1;
    // valid is held with stable data until accepted, and ready may change freely.
    logic [DATA_W-1:0]   ext_in_data;
    logic                ext_in_valid;
    logic                ext_in_ready;
    logic                ext_irq;
    logic [DATA_W-1:0]   cpu_in;
    logic                cpu_in_rd;
    logic [DATA_W-1:0]   cpu_out;
    logic                cpu_out_wr;
    logic                cpu_int;
    logic                cpu_rti;
    logic [DATA_W-1:0]   ext_out_data;
    logic                ext_out_valid;
    logic                ext_out_ready;
    logic [STATUS_W-1:0] status;

    modport master (
        output ext_in_data, ext_in_valid, ext_irq, cpu_in_rd, cpu_out, cpu_out_wr, cpu_rti,
               ext_out_ready,
        input  ext_in_ready, cpu_in, cpu_int, ext_out_data, ext_out_valid, status
    );

    modport slave (
        input  ext_in_data, ext_in_valid, ext_irq, cpu_in_rd, cpu_out, cpu_out_wr, cpu_rti,
               ext_out_ready,
        output ext_in_ready, cpu_in, cpu_int, ext_out_data, ext_out_valid, status
    );
endinterface

// File: rtl/io_interrupt_bridge_sync_fifo.sv
// First-word fall-through FIFO; extra pointer MSB distinguishes full from empty.
module io_interrupt_bridge_sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DATA_W-1:0]        head
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              push_en;
    logic              pop_en;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: head is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/io_interrupt_bridge.sv
// Bridge between external I/O and the processor: input FIFO, output register, interrupt generator.
module io_interrupt_bridge
    import io_interrupt_bridge_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int INT_PULSE  = 2,
    parameter int INT_THRESH = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    io_interrupt_bridge_if.slave          bus,
    output int_state_e                    dbg_state,
    output logic [$clog2(FIFO_DEPTH):0]   dbg_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = (INT_PULSE > 1) ? $clog2(INT_PULSE) : 1;

    logic              full;
    logic              empty;
    logic [AW:0]       count;
    logic [DATA_W-1:0] head;
    logic              underflow;
    logic              overflow;
    logic              irq_q;
    logic              irq_rise;
    logic              thresh_q;
    logic              pend;
    logic [PW-1:0]     pulse_cnt;
    int_state_e        state;
    logic [STATUS_W-1:0] status_w;

    io_interrupt_bridge_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.ext_in_valid),
        .pop   (bus.cpu_in_rd),
        .wdata (bus.ext_in_data),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (head)
    );

    assign bus.ext_in_ready = ~full;
    assign bus.cpu_in       = head;
    assign irq_rise         = bus.ext_irq & ~irq_q;
    assign dbg_state        = state;
    assign dbg_count        = count;

    always_comb begin
        status_w                 = '0;
        status_w[STAT_EMPTY]     = empty;
        status_w[STAT_FULL]      = full;
        status_w[STAT_UNDERFLOW] = underflow;
        status_w[STAT_OVERFLOW]  = overflow;
    end
    assign bus.status = status_w;

    // A new write while the sink is stalling replaces the pending word and flags the loss.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.ext_out_data  <= '0;
            bus.ext_out_valid <= 1'b0;
            overflow          <= 1'b0;
            underflow         <= 1'b0;
        end else begin
            if (bus.cpu_in_rd && empty) underflow <= 1'b1;
            if (bus.cpu_out_wr) begin
                bus.ext_out_data  <= bus.cpu_out;
                bus.ext_out_valid <= 1'b1;
                if (bus.ext_out_valid && !bus.ext_out_ready) overflow <= 1'b1;
            end else if (bus.ext_out_valid && bus.ext_out_ready) begin
                bus.ext_out_valid <= 1'b0;
            end
        end
    end

    // Occupancy is registered once before the FSM sees it, giving push-to-Int latency of two edges.
    always_ff @(posedge clk) begin
        if (!rst) begin
            irq_q     <= 1'b0;
            thresh_q  <= 1'b0;
            state     <= ST_IDLE;
            bus.cpu_int <= 1'b0;
            pulse_cnt <= '0;
            pend      <= 1'b0;
        end else begin
            irq_q    <= bus.ext_irq;
            thresh_q <= (count >= (AW+1)'(INT_THRESH));
            case (state)
                ST_IDLE: begin
                    if (thresh_q || irq_rise || pend) begin
                        state       <= ST_PULSE;
                        bus.cpu_int <= 1'b1;
                        pulse_cnt   <= PW'(INT_PULSE - 1);
                        pend        <= 1'b0;
                    end
                end
                ST_PULSE: begin
                    if (irq_rise) pend <= 1'b1;
                    if (pulse_cnt == '0) begin
                        state       <= ST_WAIT;
                        bus.cpu_int <= 1'b0;
                    end else begin
                        pulse_cnt <= pulse_cnt - 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (irq_rise) pend <= 1'b1;
                    if (bus.cpu_rti) state <= ST_IDLE;
                end
                default: begin
                    state       <= ST_IDLE;
                    bus.cpu_int <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_io_interrupt_bridge.sv
// Self-checking bench for io_interrupt_bridge: directed scenarios plus a randomized queue-model run.
module tb_io_interrupt_bridge;
    import io_interrupt_bridge_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    int_state_e dbg_state;
    logic [$clog2(DEPTH):0] dbg_count;

    io_interrupt_bridge_if #(.DATA_W(DW)) bus ();

    io_interrupt_bridge #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .INT_PULSE(2), .INT_THRESH(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state),
        .dbg_count (dbg_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ext_in_data   = '0;
        bus.ext_in_valid  = 1'b0;
        bus.ext_irq       = 1'b0;
        bus.cpu_in_rd     = 1'b0;
        bus.cpu_out       = '0;
        bus.cpu_out_wr    = 1'b0;
        bus.cpu_rti       = 1'b0;
        bus.ext_out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.status !== 4'b0001) begin bad++; $display("FAIL reset_status got=%b exp=0001", bus.status); end
        total++; if (bus.ext_in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.ext_in_ready); end
        total++; if (bus.cpu_int !== 1'b0) begin bad++; $display("FAIL reset_int got=%b exp=0", bus.cpu_int); end
        total++; if (bus.ext_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.ext_out_valid); end
        total++; if (bus.cpu_in !== 16'h0) begin bad++; $display("FAIL reset_cpu_in got=%h exp=0000", bus.cpu_in); end
        total++; if (bus.ext_out_data !== 16'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0000", bus.ext_out_data); end
        total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_fill_drain();
        logic [DW-1:0] exp_w;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            bus.ext_in_data  = 16'hA001 + 16'(i);
            bus.ext_in_valid = 1'b1;
            tick();
        end
        total++; if (bus.ext_in_ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b exp=0", bus.ext_in_ready); end
        total++; if (bus.status[STAT_FULL] !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", bus.status[STAT_FULL]); end
        bus.ext_in_data = 16'hA005;
        tick();
        bus.ext_in_valid = 1'b0;
        total++; if (dbg_count !== 3'(DEPTH)) begin bad++; $display("FAIL fill_stall_count got=%0d exp=%0d", dbg_count, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            exp_w = 16'hA001 + 16'(i);
            total++; if (bus.cpu_in !== exp_w) begin bad++; $display("FAIL drain_word%0d got=%h exp=%h", i, bus.cpu_in, exp_w); end
            bus.cpu_in_rd = 1'b1;
            tick();
            if (i == 0) begin
                total++; if (bus.ext_in_ready !== 1'b1) begin bad++; $display("FAIL drain_ready got=%b exp=1", bus.ext_in_ready); end
            end
        end
        bus.cpu_in_rd = 1'b0;
        total++; if (bus.status[STAT_EMPTY] !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", bus.status[STAT_EMPTY]); end
        total++; if (bus.cpu_in !== 16'h0) begin bad++; $display("FAIL drain_cpu_in got=%h exp=0000", bus.cpu_in); end
        total++; if (bus.status[STAT_UNDERFLOW] !== 1'b0) begin bad++; $display("FAIL drain_no_underflow got=%b exp=0", bus.status[STAT_UNDERFLOW]); end
    endtask

    task automatic test_interrupt();
        // int level expected after edges t, t+1, ..., t+4 for a push at edge t
        logic exp_int [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        bus.ext_in_data  = 16'h1234;
        bus.ext_in_valid = 1'b1;
        tick();
        bus.ext_in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            total++; if (bus.cpu_int !== exp_int[k]) begin bad++; $display("FAIL int_edge_t+%0d got=%b exp=%b", k, bus.cpu_int, exp_int[k]); end
            bus.cpu_rti = (k == 2);
            tick();
        end
        // loop ended one edge past t+4; state must have reached WAIT and stayed
        bus.cpu_rti = 1'b0;
        total++; if (dbg_state !== ST_WAIT) begin bad++; $display("FAIL int_wait_state got=%0d exp=%0d", dbg_state, ST_WAIT); end
        for (int k = 0; k < 5; k++) tick();
        total++; if (bus.cpu_int !== 1'b0) begin bad++; $display("FAIL int_held_off got=%b exp=0", bus.cpu_int); end
        bus.cpu_rti = 1'b1;
        tick();
        bus.cpu_rti = 1'b0;
        total++; if (bus.cpu_int !== 1'b0) begin bad++; $display("FAIL int_after_rti got=%b exp=0", bus.cpu_int); end
        tick();
        total++; if (bus.cpu_int !== 1'b1) begin bad++; $display("FAIL int_reraised got=%b exp=1", bus.cpu_int); end
    endtask

    task automatic test_pending_irq();
        do_reset();
        bus.ext_irq = 1'b1;
        tick();
        total++; if (bus.cpu_int !== 1'b1) begin bad++; $display("FAIL irq_first_pulse got=%b exp=1", bus.cpu_int); end
        tick();
        tick();
        total++; if (dbg_state !== ST_WAIT) begin bad++; $display("FAIL irq_wait got=%0d exp=%0d", dbg_state, ST_WAIT); end
        bus.ext_irq = 1'b0;
        tick();
        bus.ext_irq = 1'b1;
        tick();
        tick();
        total++; if (bus.cpu_int !== 1'b0) begin bad++; $display("FAIL irq_blocked_in_wait got=%b exp=0", bus.cpu_int); end
        bus.cpu_rti = 1'b1;
        tick();
        bus.cpu_rti = 1'b0;
        tick();
        total++; if (bus.cpu_int !== 1'b1) begin bad++; $display("FAIL irq_pending_pulse got=%b exp=1", bus.cpu_int); end
        tick();
        tick();
        bus.cpu_rti = 1'b1;
        tick();
        bus.cpu_rti = 1'b0;
        tick();
        tick();
        total++; if (bus.cpu_int !== 1'b0) begin bad++; $display("FAIL irq_pend_cleared got=%b exp=0", bus.cpu_int); end
        total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL irq_idle got=%0d exp=%0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_output();
        do_reset();
        bus.ext_out_ready = 1'b1;
        bus.cpu_out = 16'h1111; bus.cpu_out_wr = 1'b1;
        tick();
        bus.cpu_out = 16'h2222;
        tick();
        bus.cpu_out_wr = 1'b0;
        total++; if (bus.ext_out_valid !== 1'b1 || bus.ext_out_data !== 16'h2222) begin bad++; $display("FAIL out_wr_ready got=%b/%h exp=1/2222", bus.ext_out_valid, bus.ext_out_data); end
        total++; if (bus.status[STAT_OVERFLOW] !== 1'b0) begin bad++; $display("FAIL out_no_overflow got=%b exp=0", bus.status[STAT_OVERFLOW]); end
        tick();
        bus.ext_out_ready = 1'b0;
        bus.cpu_out = 16'hBEEF; bus.cpu_out_wr = 1'b1;
        tick();
        bus.cpu_out = 16'hCAFE;
        tick();
        bus.cpu_out_wr = 1'b0;
        total++; if (bus.ext_out_data !== 16'hCAFE) begin bad++; $display("FAIL out_overwrite got=%h exp=cafe", bus.ext_out_data); end
        total++; if (bus.status[STAT_OVERFLOW] !== 1'b1) begin bad++; $display("FAIL out_overflow got=%b exp=1", bus.status[STAT_OVERFLOW]); end
        bus.ext_out_ready = 1'b1;
        tick();
        total++; if (bus.ext_out_valid !== 1'b0 || bus.ext_out_data !== 16'hCAFE) begin bad++; $display("FAIL out_drain got=%b/%h exp=0/cafe", bus.ext_out_valid, bus.ext_out_data); end
    endtask

    task automatic test_underflow();
        do_reset();
        bus.cpu_in_rd    = 1'b1;
        bus.ext_in_data  = 16'h5555;
        bus.ext_in_valid = 1'b1;
        tick();
        bus.cpu_in_rd    = 1'b0;
        bus.ext_in_valid = 1'b0;
        total++; if (bus.status[STAT_UNDERFLOW] !== 1'b1) begin bad++; $display("FAIL udf_flag got=%b exp=1", bus.status[STAT_UNDERFLOW]); end
        total++; if (dbg_count !== 3'd1) begin bad++; $display("FAIL udf_count got=%0d exp=1", dbg_count); end
        total++; if (bus.cpu_in !== 16'h5555) begin bad++; $display("FAIL udf_cpu_in got=%h exp=5555", bus.cpu_in); end
        tick();
        tick();
        total++; if (bus.cpu_int !== 1'b1 || dbg_state !== ST_PULSE) begin bad++; $display("FAIL midrst_pre got=%b/%0d exp=1/%0d", bus.cpu_int, dbg_state, ST_PULSE); end
        rst = 1'b0;
        tick();
        total++; if (bus.cpu_int !== 1'b0 || dbg_state !== ST_IDLE) begin bad++; $display("FAIL midrst_int got=%b/%0d exp=0/%0d", bus.cpu_int, dbg_state, ST_IDLE); end
        total++; if (bus.status !== 4'b0001) begin bad++; $display("FAIL midrst_status got=%b exp=0001", bus.status); end
        rst = 1'b1;
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] m_out_data = '0;
        logic          m_out_valid = 1'b0;
        logic          m_ovf = 1'b0;
        logic          m_udf = 1'b0;
        logic [3:0]    exp_st;
        logic [DW-1:0] exp_in;
        logic          v, rd, wr, rdy;
        logic [DW-1:0] din, dout;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            exp_in = (exp_q.size() > 0) ? exp_q[0] : '0;
            exp_st = {m_ovf, m_udf, exp_q.size() == DEPTH, exp_q.size() == 0};
            total++; if (bus.cpu_in !== exp_in) begin bad++; $display("FAIL rnd_cpu_in c=%0d got=%h exp=%h", c, bus.cpu_in, exp_in); end
            total++; if (bus.status !== exp_st) begin bad++; $display("FAIL rnd_status c=%0d got=%b exp=%b", c, bus.status, exp_st); end
            total++; if (bus.ext_in_ready !== (exp_q.size() < DEPTH)) begin bad++; $display("FAIL rnd_ready c=%0d got=%b", c, bus.ext_in_ready); end
            total++; if (bus.ext_out_valid !== m_out_valid || bus.ext_out_data !== m_out_data) begin bad++; $display("FAIL rnd_out c=%0d got=%b/%h exp=%b/%h", c, bus.ext_out_valid, bus.ext_out_data, m_out_valid, m_out_data); end
            v    = ($urandom_range(0, 9) < 5);
            rd   = ($urandom_range(0, 9) < 4);
            wr   = ($urandom_range(0, 9) < 3);
            rdy  = ($urandom_range(0, 9) < 5);
            din  = 16'($urandom_range(0, 16'hFFFF));
            dout = 16'($urandom_range(0, 16'hFFFF));
            bus.ext_in_valid = v;  bus.ext_in_data = din;
            bus.cpu_in_rd = rd;    bus.cpu_out_wr = wr;
            bus.cpu_out = dout;    bus.ext_out_ready = rdy;
            if (rd && exp_q.size() == 0) m_udf = 1'b1;
            if (v && exp_q.size() < DEPTH) begin
                if (rd && exp_q.size() > 0) void'(exp_q.pop_front());
                exp_q.push_back(din);
            end else if (rd && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
            end
            if (wr) begin
                if (m_out_valid && !rdy) m_ovf = 1'b1;
                m_out_data  = dout;
                m_out_valid = 1'b1;
            end else if (m_out_valid && rdy) begin
                m_out_valid = 1'b0;
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fill_drain();
        test_interrupt();
        test_pending_irq();
        test_output();
        test_underflow();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
